// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests to
// instruction memory, and queues returned words as {instr, pc} pairs for decode.
// An execute-stage redirect loads a new PC, flushes the queues, and marks
// in-flight responses for discard. A misaligned redirect target halts fetch.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_*        request handshake (imem_addr = current fetch PC)
//   imem_rsp_*        in-order responses, one per accepted request
//   redirect, N_PC,
//   branch_taken,
//   target            next-PC select from execute
//   id_*              head of the instruction queue toward decode
//   fetch_misalign    redirect target was not 4-byte aligned; fetch halted
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [1:0]      N_PC,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_misalign
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            misalign_q, misalign_d;
  logic            started_q;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [PW-1:0]   tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;

  logic [31:0]     iq_instr_q [DEPTH];
  logic [XLEN-1:0] iq_pc_q    [DEPTH];
  logic [XLEN-1:0] tq_pc_q    [DEPTH];

  logic            take;
  logic [XLEN-1:0] new_pc;
  logic [SW-1:0]   credit_sum;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_drop;
  logic            id_pop;

  // Redirect decode: only jumps and taken branches change the PC
  assign take   = redirect && (N_PC[1] || ((N_PC == 2'b01) && branch_taken));
  assign new_pc = (N_PC == 2'b11) ? (target & ~XLEN'(1)) : target;

  // Queued + in-flight + to-be-discarded words must fit the queue
  assign credit_sum = SW'(count_q) + SW'(out_q) + SW'(drop_q);

  // started_q keeps the request low while reset is asserted
  assign imem_req_valid = started_q && !take && !misalign_q && (credit_sum < SW'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_live = imem_rsp_valid && (drop_q == '0);

  assign id_valid       = (count_q != '0);
  assign id_pop         = id_valid && id_ready;
  assign id_instr       = id_valid ? iq_instr_q[iq_rd_q] : 32'h0;
  assign id_pc          = id_valid ? iq_pc_q[iq_rd_q] : '0;
  assign fetch_misalign = misalign_q;

  // Next-state for PC, counters and queue pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    iq_wr_d    = iq_wr_q;
    iq_rd_d    = iq_rd_q;
    tq_wr_d    = tq_wr_q;
    tq_rd_d    = tq_rd_q;

    if (take) begin
      fetch_pc_d = new_pc;
      misalign_d = (new_pc[1:0] != 2'b00);
      count_d    = '0;
      out_d      = '0;
      iq_wr_d    = '0;
      iq_rd_d    = '0;
      tq_wr_d    = '0;
      tq_rd_d    = '0;
      // Every word still owed by memory becomes a discard, less any arriving now
      drop_d     = drop_q + out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        tq_wr_d    = tq_wr_q + PW'(1);
      end
      if (rsp_live) begin
        tq_rd_d = tq_rd_q + PW'(1);
        iq_wr_d = iq_wr_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (id_pop) begin
        iq_rd_d = iq_rd_q + PW'(1);
      end
      out_d   = out_q + CW'(req_fire) - CW'(rsp_live);
      count_d = count_q + CW'(rsp_live) - CW'(id_pop);
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
      started_q  <= 1'b0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
      tq_wr_q    <= '0;
      tq_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
      started_q  <= 1'b1;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
      tq_wr_q    <= tq_wr_d;
      tq_rd_q    <= tq_rd_d;
    end
  end

  // Queue storage; contents are only visible through counted entries
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tq_pc_q[tq_wr_q] <= fetch_pc_q;
    end
    if (!take && rsp_live) begin
      iq_instr_q[iq_wr_q] <= imem_rsp_data;
      iq_pc_q[iq_wr_q]    <= tq_pc_q[tq_rd_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory model
// (one cycle minimum latency, optional hold) and a handshake recorder.
module tb_instr_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data  = 32'h0;
  logic            redirect;
  logic [1:0]      N_PC;
  logic            branch_taken;
  logic [XLEN-1:0] target;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            fetch_misalign;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic        mem_hold = 1'b0;
  logic [31:0] mem_q[$];
  logic [31:0] fired_q[$];
  logic [31:0] cons_pc_q[$];
  logic [31:0] cons_instr_q[$];
  int          fire_cyc_q[$];
  int          cons_cyc_q[$];

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .N_PC           (N_PC),
    .branch_taken   (branch_taken),
    .target         (target),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  // Memory model and handshake recorder; samples pre-edge values
  always @(posedge clk) begin : mem_model
    logic        f;
    logic        c;
    logic [31:0] a;
    f = rst_n && imem_req_valid && imem_req_ready;
    a = imem_addr;
    c = rst_n && id_valid && id_ready;
    cyc++;
    if (f) begin
      fired_q.push_back(a);
      fire_cyc_q.push_back(cyc);
    end
    if (c) begin
      cons_pc_q.push_back(id_pc);
      cons_instr_q.push_back(id_instr);
      cons_cyc_q.push_back(cyc);
    end
    if (!rst_n) mem_q.delete();
    else if (f) mem_q.push_back(a);
    #1;
    if (rst_n && !mem_hold && (mem_q.size() > 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    fired_q.delete();
    fire_cyc_q.delete();
    cons_pc_q.delete();
    cons_instr_q.delete();
    cons_cyc_q.delete();
  endtask

  task automatic idle_inputs();
    redirect       = 1'b0;
    N_PC           = 2'b00;
    branch_taken   = 1'b0;
    target         = '0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    mem_hold       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic wait_cons(input int n);
    int k;
    k = 0;
    while ((cons_pc_q.size() < n) && (k < 80)) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", fetch_misalign); end
    tick();
    tick();
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_sequential();
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    wait_cons(8);
    checks++; if (cons_pc_q.size() < 8) begin failures++; $display("FAIL seq_count got=%0d exp>=8", cons_pc_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (fired_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, fired_q[i], 32'(4 * i)); end
      checks++; if (cons_pc_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, cons_pc_q[i], 32'(4 * i)); end
      checks++; if (cons_instr_q[i] !== mem_data(32'(4 * i))) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, cons_instr_q[i], mem_data(32'(4 * i))); end
    end
    checks++; if (cons_cyc_q[0] - fire_cyc_q[0] != 2) begin failures++; $display("FAIL seq_latency got=%0d exp=2", cons_cyc_q[0] - fire_cyc_q[0]); end
  endtask

  task automatic test_stall();
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    repeat (6) tick();
    #1;
    checks++; if (fired_q.size() != DEPTH) begin failures++; $display("FAIL stall_issued got=%0d exp=%0d", fired_q.size(), DEPTH); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stall_id_valid got=%b exp=1", id_valid); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL stall_id_pc got=%h exp=0", id_pc); end
    id_ready = 1'b1;
    wait_cons(6);
    checks++; if (cons_pc_q.size() < 6) begin failures++; $display("FAIL stall_resume_count got=%0d exp>=6", cons_pc_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cons_pc_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, cons_pc_q[i], 32'(4 * i)); end
      checks++; if (fired_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, fired_q[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    wait_cons(2);
    // Not-taken branch and a seq select must leave fetch untouched
    redirect = 1'b1; N_PC = 2'b01; branch_taken = 1'b0; target = 32'h100;
    tick();
    N_PC = 2'b00; branch_taken = 1'b1;
    tick();
    redirect = 1'b0; branch_taken = 1'b0;
    wait_cons(6);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cons_pc_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL nt_pc[%0d] got=%h exp=%h", i, cons_pc_q[i], 32'(4 * i)); end
    end
    // Taken branch
    id_ready = 1'b0;
    redirect = 1'b1; N_PC = 2'b01; branch_taken = 1'b1; target = 32'h100;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL take_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    redirect = 1'b0; branch_taken = 1'b0;
    clear_mon();
    #1;
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL take_addr got=%h exp=00000100", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL take_flush got=%b exp=0", id_valid); end
    id_ready = 1'b1;
    wait_cons(3);
    checks++; if (cons_pc_q.size() < 3) begin failures++; $display("FAIL take_count got=%0d exp>=3", cons_pc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cons_pc_q[i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL take_pc[%0d] got=%h exp=%h", i, cons_pc_q[i], 32'h100 + 32'(4 * i)); end
      checks++; if (cons_instr_q[i] !== mem_data(32'h100 + 32'(4 * i))) begin failures++; $display("FAIL take_instr[%0d] got=%h exp=%h", i, cons_instr_q[i], mem_data(32'h100 + 32'(4 * i))); end
    end
  endtask

  task automatic test_misalign();
    int k;
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    mem_hold       = 1'b1;
    k = 0;
    while ((fired_q.size() < 2) && (k < 10)) begin tick(); k++; end
    checks++; if (fired_q.size() != 2) begin failures++; $display("FAIL mis_outstanding got=%0d exp=2", fired_q.size()); end
    redirect = 1'b1; N_PC = 2'b11; target = 32'h203;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h202) begin failures++; $display("FAIL mis_addr got=%h exp=00000202", imem_addr); end
    checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", fetch_misalign); end
    repeat (3) tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_halt got=%b exp=0", imem_req_valid); end
    checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL mis_sticky got=%b exp=1", fetch_misalign); end
    clear_mon();
    redirect = 1'b1; N_PC = 2'b10; target = 32'h300;
    tick();
    redirect = 1'b0;
    mem_hold = 1'b0;
    #1;
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", fetch_misalign); end
    checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL mis_new_addr got=%h exp=00000300", imem_addr); end
    id_ready = 1'b1;
    wait_cons(2);
    checks++; if (cons_pc_q.size() < 2) begin failures++; $display("FAIL mis_count got=%0d exp>=2", cons_pc_q.size()); end
    checks++; if (cons_pc_q[0] !== 32'h300) begin failures++; $display("FAIL mis_first_pc got=%h exp=00000300", cons_pc_q[0]); end
    checks++; if (cons_instr_q[0] !== mem_data(32'h300)) begin failures++; $display("FAIL mis_first_instr got=%h exp=%h", cons_instr_q[0], mem_data(32'h300)); end
    checks++; if (cons_pc_q[1] !== 32'h304) begin failures++; $display("FAIL mis_second_pc got=%h exp=00000304", cons_pc_q[1]); end
  endtask

  task automatic test_same_cycle();
    int k;
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    k = 0;
    while (!imem_rsp_valid && (k < 10)) begin tick(); k++; end
    redirect = 1'b1; N_PC = 2'b10; target = 32'h400;
    tick();
    redirect = 1'b0;
    clear_mon();
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_flush got=%b exp=0", id_valid); end
    id_ready = 1'b1;
    wait_cons(2);
    checks++; if (cons_pc_q.size() < 2) begin failures++; $display("FAIL same_cycle_count got=%0d exp>=2", cons_pc_q.size()); end
    checks++; if (cons_pc_q[0] !== 32'h400) begin failures++; $display("FAIL same_cycle_pc got=%h exp=00000400", cons_pc_q[0]); end
    checks++; if (cons_instr_q[0] !== mem_data(32'h400)) begin failures++; $display("FAIL same_cycle_instr got=%h exp=%h", cons_instr_q[0], mem_data(32'h400)); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    do_reset();
    imem_req_ready = 1'b1;
    redirect = 1'b1; N_PC = 2'b10; target = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    clear_mon();
    id_ready = 1'b1;
    wait_cons(4);
    checks++; if (cons_pc_q.size() < 4) begin failures++; $display("FAIL wrap_count got=%0d exp>=4", cons_pc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fired_q[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, fired_q[i], exp_a[i]); end
      checks++; if (cons_pc_q[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, cons_pc_q[i], exp_a[i]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    repeat (6) tick();
    #1;
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b exp=1", id_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL areset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL areset_id_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL areset_id_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL areset_id_pc got=%h exp=0", id_pc); end
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL areset_misalign got=%b exp=0", fetch_misalign); end
    tick();
    tick();
    rst_n = 1'b1;
    clear_mon();
    id_ready = 1'b1;
    wait_cons(2);
    checks++; if (cons_pc_q.size() < 2) begin failures++; $display("FAIL areset_count got=%0d exp>=2", cons_pc_q.size()); end
    checks++; if (fired_q[0] !== 32'h0) begin failures++; $display("FAIL areset_restart_addr got=%h exp=0", fired_q[0]); end
    checks++; if (cons_pc_q[0] !== 32'h0) begin failures++; $display("FAIL areset_pc0 got=%h exp=0", cons_pc_q[0]); end
    checks++; if (cons_pc_q[1] !== 32'h4) begin failures++; $display("FAIL areset_pc1 got=%h exp=4", cons_pc_q[1]); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misalign();
    test_same_cycle();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
